// File: rtl/modem_ctrl_array.sv
// Multi-channel 16550-style modem control/status: per-channel input sync + debounce,
// MCR/MSR with sticky deltas, loopback, auto-RTS/CTS flow control and modem-status irq.
module modem_ctrl_array #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] nCTS,
  input  logic [NUM_CH-1:0] nDSR,
  input  logic [NUM_CH-1:0] nRI,
  input  logic [NUM_CH-1:0] nDCD,
  output logic [NUM_CH-1:0] nRTS,
  output logic [NUM_CH-1:0] nDTR,
  output logic [NUM_CH-1:0] OUT1,
  output logic [NUM_CH-1:0] OUT2,
  input  logic              mcr_wr,
  input  logic [CH_W-1:0]   mcr_ch,
  input  logic [5:0]        mcr_wdata,
  input  logic              msr_rd,
  input  logic [CH_W-1:0]   msr_ch,
  output logic [7:0]        msr_rdata,
  input  logic [NUM_CH-1:0] msi_en,
  input  logic [NUM_CH-1:0] rx_almost_full,
  output logic [NUM_CH-1:0] irq,
  output logic [NUM_CH-1:0] tx_hold
);

  logic [NUM_CH-1:0]      wr_sel, rd_sel;
  logic [NUM_CH-1:0][7:0] ch_msr;
  logic [7:0]             rdata_q, rdata_d;

  // Address decode; out-of-range channels select nothing and read back zero.
  always_comb begin
    wr_sel  = '0;
    rd_sel  = '0;
    rdata_d = rdata_q;
    if (mcr_wr && (int'(mcr_ch) < NUM_CH)) wr_sel[mcr_ch] = 1'b1;
    if (msr_rd) begin
      rdata_d = '0;
      if (int'(msr_ch) < NUM_CH) begin
        rd_sel[msr_ch] = 1'b1;
        rdata_d        = ch_msr[msr_ch];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign msr_rdata = rdata_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Line order in every 4-bit vector: [0] CTS, [1] DSR, [2] RI, [3] DCD.
    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [3:0][7:0]             cnt_q, cnt_d;
    logic [3:0]                  deb_q, deb_d;
    logic [3:0]                  stat_q, stat_d;
    logic [3:0]                  dlt_q, dlt_d;
    logic [3:0]                  evt;
    logic [5:0]                  mcr_q, mcr_d;
    logic                        nrts_q, nrts_d, ndtr_q, ndtr_d;
    logic                        out1_q, out1_d, out2_q, out2_d;
    logic                        irq_q, irq_d, txh_q, txh_d;

    always_comb begin
      sync_d[0] = {nDCD[g], nRI[g], nDSR[g], nCTS[g]};
      for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];

      deb_d = deb_q;
      cnt_d = '0;
      for (int ln = 0; ln < 4; ln++) begin
        if (sync_q[SYNC_STAGES-1][ln] != deb_q[ln]) begin
          if (cnt_q[ln] == 8'(DEBOUNCE_CYCLES - 1)) deb_d[ln] = sync_q[SYNC_STAGES-1][ln];
          else                                      cnt_d[ln] = cnt_q[ln] + 8'd1;
        end
      end

      mcr_d = wr_sel[g] ? mcr_wdata : mcr_q;

      // Status follows the fresh debounced level so pad-to-status is SYNC+DEB cycles;
      // loopback sources come from the registered MCR, hence one cycle after a write.
      stat_d = mcr_q[4] ? {mcr_q[3], mcr_q[2], mcr_q[0], mcr_q[1]} : ~deb_d;
      evt    = {stat_q[3] ^ stat_d[3], stat_q[2] & ~stat_d[2],
                stat_q[1] ^ stat_d[1], stat_q[0] ^ stat_d[0]};
      dlt_d  = (rd_sel[g] ? 4'b0000 : dlt_q) | evt;

      nrts_d = mcr_d[4] | ~(mcr_d[1] & ~(mcr_d[5] & rx_almost_full[g]));
      ndtr_d = mcr_d[4] | ~mcr_d[0];
      out1_d = mcr_d[4] | ~mcr_d[2];
      out2_d = mcr_d[4] | ~mcr_d[3];
      txh_d  = mcr_d[5] & ~stat_q[0];
      irq_d  = msi_en[g] & (|dlt_q);
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        sync_q <= '1;
        cnt_q  <= '0;
        deb_q  <= '1;
        stat_q <= '0;
        dlt_q  <= '0;
        mcr_q  <= '0;
        nrts_q <= 1'b1;
        ndtr_q <= 1'b1;
        out1_q <= 1'b1;
        out2_q <= 1'b1;
        irq_q  <= 1'b0;
        txh_q  <= 1'b0;
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        deb_q  <= deb_d;
        stat_q <= stat_d;
        dlt_q  <= dlt_d;
        mcr_q  <= mcr_d;
        nrts_q <= nrts_d;
        ndtr_q <= ndtr_d;
        out1_q <= out1_d;
        out2_q <= out2_d;
        irq_q  <= irq_d;
        txh_q  <= txh_d;
      end
    end

    assign nRTS[g]    = nrts_q;
    assign nDTR[g]    = ndtr_q;
    assign OUT1[g]    = out1_q;
    assign OUT2[g]    = out2_q;
    assign irq[g]     = irq_q;
    assign tx_hold[g] = txh_q;
    assign ch_msr[g]  = {stat_q, dlt_q};
  end

endmodule
